// File: rtl/wb_sequencer_if.sv
// wb_sequencer_if -- write-back request/grant and register-file write bundle.
//
// Signals:
//   req         [6:0]  write-back requests, bit i-1 = source i (1..7)
//   dest        [34:0] destination register per source, source i at [5i-1:5i-5]
//   stall       1      blocks new grants and holds a selected transfer
//   ack         [6:0]  one-hot, one-cycle grant pulse, bit i-1 = source i
//   reg_src_sel [2:0]  register-source mux select (0 = constant 227 source)
//   reg_dst     [4:0]  register-file write address
//   reg_write   1      register-file write enable
//   busy        1      low only while the sequencer is idle
//   init_done   1      stack-pointer init write has completed
//
// Modports:
//   master -- the sequencer (drives grants and the register-file write port)
//   slave  -- requesters / register file side
interface wb_sequencer_if;
  logic [6:0]  req;
  logic [34:0] dest;
  logic        stall;
  logic [6:0]  ack;
  logic [2:0]  reg_src_sel;
  logic [4:0]  reg_dst;
  logic        reg_write;
  logic        busy;
  logic        init_done;

  modport master (
    input  req, dest, stall,
    output ack, reg_src_sel, reg_dst, reg_write, busy, init_done
  );

  modport slave (
    output req, dest, stall,
    input  ack, reg_src_sel, reg_dst, reg_write, busy, init_done
  );
endinterface

// File: rtl/wb_sequencer.sv
// wb_sequencer -- arbitrates seven write-back sources onto a single
// register-file write port. After every reset it first writes the constant
// 227 source into register 29 (stack pointer), then serves requests with a
// select cycle (SEL, ack pulse) followed by a write cycle (WR, reg_write).
// A new grant may be issued from the WR cycle, giving one write per two
// cycles under sustained load.
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   synchronous, active-high reset
//   bus    wb_sequencer_if.master (req, dest, stall in; ack, reg_src_sel,
//          reg_dst, reg_write, busy, init_done out)
//
// Configuration:
//   WB_RR_EN  defined   -> round-robin arbitration, search starts at source
//                          (last_grant mod 7)+1 and wraps 7 -> 1
//             undefined -> fixed priority, lowest-numbered source wins
//
// All outputs come straight from registers.
module wb_sequencer (
  input  logic           clk,
  input  logic           reset,
  wb_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    INIT_SEL = 3'd0,
    INIT_WR  = 3'd1,
    IDLE     = 3'd2,
    SEL      = 3'd3,
    WR       = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  sel_q, sel_d;
  logic [4:0]  dst_q, dst_d;
  logic        we_q, we_d;
  logic [6:0]  ack_q, ack_d;
  logic        busy_q, busy_d;
  logic        init_done_q, init_done_d;

  logic        grant_valid;
  logic [2:0]  winner_idx;   // bit index of the winning source (0..6)
  logic [4:0]  dest_arr [0:6];

  // Unpack the per-source destination fields.
  for (genvar gi = 0; gi < 7; gi++) begin : g_dest
    assign dest_arr[gi] = bus.dest[gi*5 +: 5];
  end

`ifdef WB_RR_EN
  logic [2:0] last_q, last_d;   // last granted source number (1..7)

  always_comb begin
    int start;
    int idx;
    grant_valid = 1'b0;
    winner_idx  = 3'd0;
    // Source (last mod 7)+1 sits at bit index (last mod 7).
    start = (last_q == 3'd7) ? 0 : int'(last_q);
    for (int k = 0; k < 7; k++) begin
      idx = start + k;
      if (idx >= 7) idx = idx - 7;
      if (!grant_valid && bus.req[idx]) begin
        grant_valid = 1'b1;
        winner_idx  = 3'(idx);
      end
    end
  end
`else
  always_comb begin
    grant_valid = 1'b0;
    winner_idx  = 3'd0;
    for (int k = 0; k < 7; k++) begin
      if (!grant_valid && bus.req[k]) begin
        grant_valid = 1'b1;
        winner_idx  = 3'(k);
      end
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    dst_d       = dst_q;
    we_d        = 1'b0;
    ack_d       = 7'd0;
    init_done_d = init_done_q | (state_q == IDLE);
`ifdef WB_RR_EN
    last_d      = last_q;
`endif

    case (state_q)
      // The reset cycle already occupies INIT_SEL with cleared outputs, so
      // the constant select/address are registered on leaving INIT_SEL and
      // the write strobe on leaving INIT_WR.
      INIT_SEL: begin
        sel_d   = 3'd0;
        dst_d   = 5'd29;
        state_d = INIT_WR;
      end
      INIT_WR: begin
        we_d    = 1'b1;
        state_d = IDLE;
      end
      IDLE, WR: begin
        if (!bus.stall && grant_valid) begin
          sel_d   = winner_idx + 3'd1;
          dst_d   = dest_arr[winner_idx];
          ack_d   = 7'd1 << winner_idx;
          state_d = SEL;
`ifdef WB_RR_EN
          last_d  = winner_idx + 3'd1;
`endif
        end else begin
          state_d = IDLE;
          // Move the mux off the constant source once init is over.
          if (sel_q == 3'd0) sel_d = 3'd1;
        end
      end
      SEL: begin
        // Write strobe lands in the WR cycle; a zero destination is
        // acknowledged but never written.
        if (!bus.stall) begin
          we_d    = (dst_q != 5'd0);
          state_d = WR;
        end
      end
      default: state_d = INIT_SEL;
    endcase

    // Busy covers every cycle except a quiet IDLE (including the init
    // strobe that lands as IDLE is entered).
    busy_d = !((state_d == IDLE) && !we_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= INIT_SEL;
      sel_q       <= 3'd0;
      dst_q       <= 5'd0;
      we_q        <= 1'b0;
      ack_q       <= 7'd0;
      busy_q      <= 1'b1;
      init_done_q <= 1'b0;
`ifdef WB_RR_EN
      last_q      <= 3'd7;
`endif
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      dst_q       <= dst_d;
      we_q        <= we_d;
      ack_q       <= ack_d;
      busy_q      <= busy_d;
      init_done_q <= init_done_d;
`ifdef WB_RR_EN
      last_q      <= last_d;
`endif
    end
  end

  assign bus.ack         = ack_q;
  assign bus.reg_src_sel = sel_q;
  assign bus.reg_dst     = dst_q;
  assign bus.reg_write   = we_q;
  assign bus.busy        = busy_q;
  assign bus.init_done   = init_done_q;

endmodule

// File: tb/tb_wb_sequencer.sv
// tb_wb_sequencer -- self-checking bench for wb_sequencer: init write,
// table-driven single-request vectors, hand-written multi-cycle sequences
// (back-to-back arbitration, reset in WR) and a randomized run against a
// transaction-level reference model.
module tb_wb_sequencer;

  logic clk;
  logic reset;
  wb_sequencer_if bus_if ();

  wb_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_miss;

  // Table destinations: src1=11, src2=0, src3=8, src4=14, src5=15, src6=16, src7=17
  localparam logic [34:0] TAB_DEST = {5'd17, 5'd16, 5'd15, 5'd14, 5'd8, 5'd0, 5'd11};

  typedef struct {
    logic [6:0] req;
    logic       stall;
    logic [6:0] ack;
    logic [2:0] sel;
    logic [4:0] dst;
    logic       we;
    logic       busy;
  } vec_t;

  vec_t tab [16];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arbitration rule, in source numbers 1..7.
  function automatic int pick(input logic [6:0] r, input int last);
`ifdef WB_RR_EN
    for (int k = 0; k < 7; k++) begin
      int s;
      s = (last % 7) + 1 + k;
      if (s > 7) s = s - 7;
      if (r[s-1]) return s;
    end
`else
    for (int s = 1; s <= 7; s++) begin
      if (r[s-1]) return s;
    end
`endif
    return 0;
  endfunction

  task automatic check_init();
    reset = 1'b0;
    step();
    check("init1_sel", 32'(bus_if.reg_src_sel), 0);
    check("init1_dst", 32'(bus_if.reg_dst), 29);
    check("init1_we", 32'(bus_if.reg_write), 0);
    step();
    check("init2_we", 32'(bus_if.reg_write), 1);
    check("init2_dst", 32'(bus_if.reg_dst), 29);
    step();
    check("init3_we", 32'(bus_if.reg_write), 0);
    check("init3_done", 32'(bus_if.init_done), 1);
    check("init3_busy", 32'(bus_if.busy), 0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ack"}, 32'(bus_if.ack), 0);
    check({tag, "_sel"}, 32'(bus_if.reg_src_sel), 0);
    check({tag, "_dst"}, 32'(bus_if.reg_dst), 0);
    check({tag, "_we"}, 32'(bus_if.reg_write), 0);
    check({tag, "_busy"}, 32'(bus_if.busy), 1);
    check({tag, "_done"}, 32'(bus_if.init_done), 0);
  endtask

  initial begin
    logic [6:0] r;
    logic       s;
    logic [34:0] d;
    logic [63:0] rnd;
    logic [6:0] exp_ack;
    logic       exp_we;
    logic       wrote;
    logic       in_flight;
    logic [2:0] m_sel;
    logic [4:0] m_dst;
    int         m_last;
    int         w;
    int         exp_src;

    n_vec  = 0;
    n_miss = 0;

    tab[0]  = '{7'b0000100, 1'b0, 7'b0000100, 3'd3, 5'd8,  1'b0, 1'b1};
    tab[1]  = '{7'b0000000, 1'b0, 7'b0000000, 3'd3, 5'd8,  1'b1, 1'b1};
    tab[2]  = '{7'b0000000, 1'b0, 7'b0000000, 3'd3, 5'd8,  1'b0, 1'b0};
    tab[3]  = '{7'b0000010, 1'b0, 7'b0000010, 3'd2, 5'd0,  1'b0, 1'b1};
    tab[4]  = '{7'b0000000, 1'b0, 7'b0000000, 3'd2, 5'd0,  1'b0, 1'b1};
    tab[5]  = '{7'b0001000, 1'b0, 7'b0001000, 3'd4, 5'd14, 1'b0, 1'b1};
    tab[6]  = '{7'b0000000, 1'b1, 7'b0000000, 3'd4, 5'd14, 1'b0, 1'b1};
    tab[7]  = '{7'b0000000, 1'b1, 7'b0000000, 3'd4, 5'd14, 1'b0, 1'b1};
    tab[8]  = '{7'b0000000, 1'b1, 7'b0000000, 3'd4, 5'd14, 1'b0, 1'b1};
    tab[9]  = '{7'b0000000, 1'b0, 7'b0000000, 3'd4, 5'd14, 1'b1, 1'b1};
    tab[10] = '{7'b1000000, 1'b0, 7'b1000000, 3'd7, 5'd17, 1'b0, 1'b1};
    tab[11] = '{7'b0000000, 1'b0, 7'b0000000, 3'd7, 5'd17, 1'b1, 1'b1};
    tab[12] = '{7'b0000001, 1'b1, 7'b0000000, 3'd7, 5'd17, 1'b0, 1'b0};
    tab[13] = '{7'b0000001, 1'b0, 7'b0000001, 3'd1, 5'd11, 1'b0, 1'b1};
    tab[14] = '{7'b0000000, 1'b0, 7'b0000001 & 7'b0, 3'd1, 5'd11, 1'b1, 1'b1};
    tab[15] = '{7'b0000000, 1'b0, 7'b0000000, 3'd1, 5'd11, 1'b0, 1'b0};

    // ---- reset and init write ----
    reset = 1'b1;
    bus_if.req   = 7'd0;
    bus_if.dest  = TAB_DEST;
    bus_if.stall = 1'b0;
    step();
    step();
    check_reset_state("rst");
    check_init();

    // ---- sustained two-source request ----
    bus_if.req = 7'b1000001;
    for (int g = 0; g < 4; g++) begin
`ifdef WB_RR_EN
      exp_src = (g % 2 == 0) ? 1 : 7;
`else
      exp_src = 1;
`endif
      step();
      check("b2b_ack", 32'(bus_if.ack), 32'(1) << (exp_src - 1));
      check("b2b_sel", 32'(bus_if.reg_src_sel), 32'(exp_src));
      step();
      check("b2b_we", 32'(bus_if.reg_write), 1);
      check("b2b_ack_off", 32'(bus_if.ack), 0);
      $display("b2b grant %0d -> src %0d", g, bus_if.reg_src_sel);
    end
    bus_if.req = 7'd0;
    step();
    check("b2b_idle_busy", 32'(bus_if.busy), 0);

    // ---- table-driven vectors ----
    for (int i = 0; i < 16; i++) begin
      bus_if.req   = tab[i].req;
      bus_if.stall = tab[i].stall;
      step();
      check($sformatf("tab%0d_ack", i), 32'(bus_if.ack), 32'(tab[i].ack));
      check($sformatf("tab%0d_sel", i), 32'(bus_if.reg_src_sel), 32'(tab[i].sel));
      check($sformatf("tab%0d_dst", i), 32'(bus_if.reg_dst), 32'(tab[i].dst));
      check($sformatf("tab%0d_we", i), 32'(bus_if.reg_write), 32'(tab[i].we));
      check($sformatf("tab%0d_busy", i), 32'(bus_if.busy), 32'(tab[i].busy));
      $display("vec %0d req=%b stall=%b -> ack=%b sel=%0d dst=%0d we=%b busy=%b", i,
               tab[i].req, tab[i].stall, bus_if.ack, bus_if.reg_src_sel,
               bus_if.reg_dst, bus_if.reg_write, bus_if.busy);
    end

    // ---- reset asserted during WR ----
    bus_if.req = 7'b0000100;
    step();
    check("rwr_ack", 32'(bus_if.ack), 32'h4);
    bus_if.req = 7'd0;
    step();
    check("rwr_we", 32'(bus_if.reg_write), 1);
    reset = 1'b1;
    step();
    check_reset_state("rwr");
    check_init();
    $display("reset in WR: init write repeated");

    // ---- randomized run against a transaction-level model ----
    in_flight = 1'b0;
    m_last    = 7;
    m_sel     = 3'd0;
    m_dst     = 5'd0;
    for (int c = 0; c < 600; c++) begin
      r   = 7'($urandom & $urandom);
      s   = ($urandom_range(0, 3) == 0);
      rnd = {$urandom, $urandom};
      d   = rnd[34:0];
      if ($urandom_range(0, 7) == 0) d = 35'd0;
      bus_if.req   = r;
      bus_if.stall = s;
      bus_if.dest  = d;
      step();

      exp_ack = 7'd0;
      exp_we  = 1'b0;
      wrote   = 1'b0;
      if (in_flight) begin
        if (!s) begin
          in_flight = 1'b0;
          wrote     = 1'b1;
          exp_we    = (m_dst != 5'd0);
        end
      end else if (!s && r != 7'd0) begin
        w         = pick(r, m_last);
        exp_ack   = 7'(1 << (w - 1));
        m_sel     = 3'(w);
        m_dst     = d[(w-1)*5 +: 5];
        in_flight = 1'b1;
        m_last    = w;
        $display("rand cyc %0d grant src %0d dst %0d", c, w, m_dst);
      end

      check("rnd_ack", 32'(bus_if.ack), 32'(exp_ack));
      check("rnd_we", 32'(bus_if.reg_write), 32'(exp_we));
      check("rnd_busy", 32'(bus_if.busy), 32'(in_flight | wrote));
      check("rnd_sel_nonzero", 32'(bus_if.reg_src_sel != 3'd0), 1);
      if (in_flight || wrote) begin
        check("rnd_sel", 32'(bus_if.reg_src_sel), 32'(m_sel));
        check("rnd_dst", 32'(bus_if.reg_dst), 32'(m_dst));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/wb_sequencer.md
WB_SEQUENCER -- requirements
Module: wb_sequencer

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk, reset.
REQ-002 The block SHALL have port clk  in  1  rising-edge clock.
REQ-003 The block SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 The block SHALL have port req  in  7  write-back request; bit i-1 = register-source input i (1..7).
REQ-005 The block SHALL have port dest  in  35  destination register per source; source i at bits [5i-1:5i-5].
REQ-006 The block SHALL have port stall  in  1  when high, no new grant is issued.
REQ-007 The block SHALL have port ack  out  7  one-hot, one-cycle grant pulse; bit i-1 = source i.
REQ-008 The block SHALL have port reg_src_sel  out  3  select code for the register-source mux.
REQ-009 The block SHALL have port reg_dst  out  5  register-file write address.
REQ-010 The block SHALL have port reg_write  out  1  register-file write enable.
REQ-011 The block SHALL have port busy  out  1  high in every state except IDLE.
REQ-012 The block SHALL have port init_done  out  1  high once the stack-pointer init write has completed.

Function
REQ-013 The block SHALL implement the states INIT_SEL, INIT_WR, IDLE, SEL and WR.
REQ-014 In INIT_SEL, the block SHALL drive reg_src_sel=0 (the constant 227 source) and reg_dst=29, then go to INIT_WR unconditionally, ignoring stall and req.
REQ-015 In INIT_WR, the block SHALL assert reg_write=1 for exactly one cycle, then go to IDLE; init_done SHALL go high on entry to IDLE and stay high until reset.
REQ-016 In IDLE or WR, if stall=0 and req is nonzero, the block SHALL choose winner w, register reg_src_sel=w and reg_dst=dest[w], pulse ack[w-1] high during the following SEL cycle, and go to SEL.
REQ-017 In IDLE or WR, if stall=1 or req=0, the block SHALL go to (or stay in) IDLE with ack=0.
REQ-018 In SEL, the block SHALL hold reg_src_sel and reg_dst, keep reg_write=0, and not sample req.
REQ-019 SEL SHALL advance to WR when stall=0 and hold otherwise.
REQ-020 In WR, the block SHALL assert reg_write=1 for one cycle, with reg_src_sel and reg_dst unchanged from SEL.
REQ-021 A granted write with dest=0 SHALL still be acked, but reg_write SHALL stay 0 in its WR cycle.
REQ-022 Sustained throughput SHALL be one write per 2 cycles, via the WR to SEL back-to-back path.
REQ-023 A requester SHALL drop its req bit in the cycle after its ack is high; a req still high at the next arbitration point SHALL be treated as a new request.
REQ-024 All outputs SHALL be registered, and reg_src_sel SHALL never take the value 0 outside INIT_SEL and INIT_WR.

Reset
REQ-025 On reset=1 at a rising edge, the block SHALL set state=INIT_SEL, reg_src_sel=0, reg_dst=0, reg_write=0, ack=0, busy=1, init_done=0, and the round-robin pointer to 7.
REQ-026 Reset asserted mid-transfer, in SEL or WR, SHALL abort that transfer with no reg_write pulse in the reset cycle.
REQ-027 After reset is released, the block SHALL rerun the init write.

Configuration
REQ-028 With macro WB_RR_EN defined, arbitration SHALL be round-robin: the search starts at source (last_grant mod 7)+1 and wraps from 7 to 1, and the pointer updates on each grant.
REQ-029 Without WB_RR_EN, arbitration SHALL be fixed priority, with the lowest-numbered source winning and no pointer register.

Verification
REQ-030 Release reset with req=0 -> cycle 1 sel=0 dst=29 we=0; cycle 2 we=1; cycle 3 IDLE, init_done=1, busy=0.
REQ-031 In IDLE, req=7'b0000100 with dest source 3=5'd8 -> next cycle ack=7'b0000100 and sel=3, dst=8, we=0; the following cycle we=1.
REQ-032 Hold req=7'b1000001 continuously -> with WB_RR_EN, grants alternate 1,7,1,7 every 2 cycles; without it, grants are 1,1,1.
REQ-033 Grant source 2 with dest=0 -> ack pulses and reg_write stays 0 throughout.
REQ-034 stall=1 asserted during SEL for 3 cycles -> sel and dst are held, we=0; we=1 occurs exactly one cycle after stall falls.
REQ-035 Reset asserted in WR -> we=0 in the following cycle, state=INIT_SEL, and the 29/227 init write is repeated.
